// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 access codes,
// FSM states, byte-enable patterns and small access-decoding helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } access_size_e;

  // Reserved funct3 codes (011, 110, 111) fall through to word size.
  function automatic access_size_e access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (access_size(f3))
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the addressed byte/half from a
// bus word and sign- or zero-extends it; shared with the single-cycle model.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE -> REQ -> DONE handshake on the data bus,
// stalling the pipeline until each access completes. Optional misaligned-access
// trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [31:0]       AluResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              MisalignM,
`endif
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready
);

  lsu_state_e         r_state;
  lsu_state_e         w_state_next;
  logic [ADDR_W-1:2]  r_word_addr;
  logic [1:0]         r_addr_lo;
  logic [2:0]         r_funct3;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic               r_we;
  logic [31:0]        r_read_data;

  logic               w_pending;
  logic               w_issue;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_load_data;

  assign w_pending = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = is_misaligned(Funct3M, AluResultM[1:0]);
  assign w_issue    = w_pending & ~w_misalign;
  assign MisalignM  = ~rst & (r_state == ST_IDLE) & w_pending & w_misalign;
`else
  // Low address bits below the access size are simply dropped by the lane math.
  assign w_issue    = w_pending;
`endif

  // Lane placement: byte/half shift into position, store data replicated across lanes.
  always_comb begin
    w_be    = BE_W;
    w_wdata = WriteDataM;
    case (access_size(Funct3M))
      SZ_B: begin
        w_be    = BE_B << AluResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        w_be    = BE_H << {AluResultM[1], 1'b0};
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be    = BE_W;
        w_wdata = WriteDataM;
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_state_next = ST_REQ;
      ST_REQ:  if (dmem_ready) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  load_formatter u_load_formatter (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_word_addr <= '0;
      r_addr_lo   <= '0;
      r_funct3    <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_issue) begin
        r_word_addr <= AluResultM[ADDR_W-1:2];
        r_addr_lo   <= AluResultM[1:0];
        r_funct3    <= Funct3M;
        r_be        <= w_be;
        r_wdata     <= w_wdata;
        r_we        <= MemWriteM;
      end
      if (r_state == ST_REQ && dmem_ready && !r_we) begin
        r_read_data <= w_load_data;
      end
    end
  end

  // Stall asserts combinationally in IDLE so the pipeline freezes the same cycle.
  assign StallM     = ~rst & ((r_state == ST_REQ) | ((r_state == ST_IDLE) & w_issue));
  assign dmem_req   = (r_state == ST_REQ);
  assign dmem_we    = r_we;
  assign dmem_addr  = {r_word_addr, 2'b00};
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign ReadDataM  = r_read_data;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: byte-level reference model plus
// directed vectors; works with or without LSU_MISALIGN_TRAP_EN.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AluResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        MisalignM;
  logic        exp_mis = 1'b0;
  int          mis_cnt = 0;
`endif

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .AluResultM (AluResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
`ifdef LSU_MISALIGN_TRAP_EN
    .MisalignM  (MisalignM),
`endif
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accesses viewed as n contiguous bytes within a word.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int base_of(input logic [2:0] f3, input logic [31:0] addr);
    int n = size_of(f3);
    return (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be = '0;
    for (int k = 0; k < size_of(f3); k++) be[base_of(f3, addr) + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r = '0;
    int n = size_of(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int n = size_of(f3);
    logic [31:0] v = word >> (8 * base_of(f3, addr));
    logic [31:0] mask;
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % size_of(f3)) != 0;
  endfunction
`endif

  // Per-cycle expectations, owned by the driver, consumed at the negedge.
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, model_rdata = '0;
  logic [3:0]  exp_be = '0;
  int          stall_cnt = 0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic        last_we = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("StallM", 32'(StallM), 32'(exp_stall));
      check("dmem_req", 32'(dmem_req), 32'(exp_req));
      check("ReadDataM", ReadDataM, model_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
      check("MisalignM", 32'(MisalignM), 32'(exp_mis));
      if (MisalignM) mis_cnt++;
`endif
      if (exp_req) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_be", 32'(dmem_be), 32'(exp_be));
        check("dmem_we", 32'(dmem_we), 32'(exp_we));
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (StallM) stall_cnt++;
      if (dmem_req) begin
        last_be = dmem_be; last_addr = dmem_addr; last_wdata = dmem_wdata; last_we = dmem_we;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    exp_stall = 1'b0; exp_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      dmem_ready = k[0];
      dmem_rdata = $urandom;
      cycle();
    end
    dmem_ready = 1'b0;
  endtask

  // One complete access; spurious ready in IDLE and DONE must be ignored.
  task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] mword, input int waits);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; AluResultM = addr; WriteDataM = wd;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_be    = model_be(f3, addr);
    exp_wdata = model_wdata(f3, wd);
    exp_we    = wr;
    stall_cnt = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (model_misaligned(f3, addr)) begin
      exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b1;
      dmem_ready = 1'b1; dmem_rdata = ~mword;
      cycle();
      exp_mis = 1'b0;
      idle_inputs();
      return;
    end
`endif
    exp_stall = 1'b1; exp_req = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = ~mword;
    cycle();
    for (int k = 0; k <= waits; k++) begin
      exp_req    = 1'b1;
      dmem_ready = (k == waits);
      dmem_rdata = (k == waits) ? mword : ~mword;
      cycle();
    end
    if (rd && !wr) model_rdata = model_load(f3, addr, mword);
    exp_stall = 1'b0; exp_req = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = ~mword;
    cycle();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    AluResultM = '0; WriteDataM = '0; dmem_rdata = '0; dmem_ready = 1'b0;
    #3;
    check("rst_ReadDataM", ReadDataM, 32'h0);
    check("rst_dmem_req", 32'(dmem_req), 32'h0);
    check("rst_dmem_we", 32'(dmem_we), 32'h0);
    check("rst_dmem_be", 32'(dmem_be), 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    MemReadM = 1'b1;
    #1;
    check("rst_StallM_pending", 32'(StallM), 32'h0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    idle(3);

    // LW, two wait states
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
    check("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    check("lw_be", 32'(last_be), 32'hF);
    check("lw_ReadDataM", ReadDataM, 32'hDEAD_BEEF);

    // LB then LBU on the same byte, back to back
    mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
    check("lb_ReadDataM", ReadDataM, 32'hFFFF_FF80);
    mem_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
    check("lbu_ReadDataM", ReadDataM, 32'h0000_0080);

    // SH, ready immediately
    mem_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
    check("sh_we", 32'(last_we), 32'h1);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wdata, 32'hABCD_ABCD);
    check("sh_stall_cycles", 32'(stall_cnt), 32'd2);
    check("sh_ReadDataM_kept", ReadDataM, 32'h0000_0080);

    // Read and write both set: store wins
    mem_op(1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 1);
    check("both_be", 32'(last_be), 32'h2);
    check("both_we", 32'(last_we), 32'h1);
    check("both_ReadDataM_kept", ReadDataM, 32'h0000_0080);

    idle(2);

    mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
    check("lh_ReadDataM", ReadDataM, 32'hFFFF_8001);
    mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h1234_F00D, 3);
    mem_op(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1);
    mem_op(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0);
    check("sb_be", 32'(last_be), 32'h8);
    mem_op(1'b1, 1'b0, 3'b011, 32'h0000_0020, 32'h0, 32'h0BAD_C0DE, 0);
    mem_op(1'b0, 1'b1, 3'b110, 32'h0000_0024, 32'h7654_3210, 32'h0, 0);
    mem_op(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0000_1357, 32'h0, 0);

    idle(1);

    // Misaligned word access
    mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1122_3344, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_trap_count", 32'(mis_cnt), 32'd2);
    check("mis_ReadDataM_kept", ReadDataM, 32'h0BAD_C0DE);
`else
    check("mis_be", 32'(last_be), 32'hF);
    check("mis_addr", last_addr, 32'h0000_0100);
    check("mis_ReadDataM", ReadDataM, 32'h1122_3344);
`endif

    idle(2);

    // Asynchronous reset while waiting in REQ
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; AluResultM = 32'h0000_0300;
    exp_addr = 32'h0000_0300; exp_be = 4'hF; exp_we = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; dmem_ready = 1'b0;
    cycle();
    exp_req = 1'b1;
    @(negedge clk); #2;
    rst = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; model_rdata = 32'h0;
    #1;
    check("rst_mid_req", 32'(dmem_req), 32'h0);
    check("rst_mid_stall", 32'(StallM), 32'h0);
    cycle();
    MemReadM = 1'b0;
    cycle();
    rst = 1'b0;
    idle(4);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the pipelined RV32I core.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Drives a req/ready data-memory bus with byte enables, formats load data (sign/zero extension), and stalls the pipeline until each access completes.
- Its ReadDataM output feeds the MEM/WB register directly.

Parameters:
- ADDR_W, 32, data-memory address width; the low ADDR_W bits of AluResultM are used.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- Funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- AluResultM  in  32  effective address
- WriteDataM  in  32  store data (rs2)
- ReadDataM  out  32  formatted load data to MEM/WB
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- dmem_ready  in  1  access complete this cycle

Behaviour:
- Reset values: all registered outputs 0; ReadDataM=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0; FSM=IDLE. StallM=0 while in reset.
- Access pending = MemReadM | MemWriteM. If both are asserted, the access is a store.
- FSM IDLE:
  - On pending, StallM=1 combinationally in the same cycle.
  - Register addr/be/wdata/we; next state REQ.
- FSM REQ:
  - dmem_req=1 and StallM=1.
  - Address, be, wdata and we are held stable until dmem_ready.
  - On dmem_ready: a load captures the formatted dmem_rdata into ReadDataM; next state DONE.
  - dmem_ready seen in the same cycle req rises completes the access.
- FSM DONE:
  - dmem_req=0 and StallM=0 for exactly one cycle, so the pipeline advances and MEM/WB captures ReadDataM.
  - Next state IDLE.
- Latency: 3 cycles minimum per memory op (IDLE, REQ, DONE), plus one cycle per extra wait state. Non-memory instructions pass with StallM=0 and zero added latency.
- ReadDataM holds its last value outside load completion. Stores never modify it.
- Byte enables:
  - B: 0001<<addr[1:0]
  - H: 0011<<{addr[1],1'b0}
  - W: 1111
- Store data replication:
  - SB: {4{wd[7:0]}}
  - SH: {2{wd[15:0]}}
  - SW: wd
- Load formatting:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Reserved Funct3 values (011, 110, 111) are treated as word access.
- dmem_ready while not in REQ is ignored.
- Asynchronous reset mid-access: dmem_req drops immediately, the FSM returns to IDLE, and the access is abandoned with no retry.
- Back-to-back memory ops: DONE→IDLE→REQ, so there is one unstalled cycle between accesses.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠00, is misaligned.
  - A misaligned access issues no bus request (FSM stays IDLE) and gives StallM=0.
  - Extra output MisalignM (1 bit, combinational, reset 0) =1 for that cycle.
  - ReadDataM is unchanged.
- Undefined:
  - No MisalignM port.
  - The offending low address bits are ignored for be/lane selection: halfword uses addr[1], word uses 1111.
  - The access proceeds normally.

Decomposition:
- Package lsu_pkg:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state enum (IDLE, REQ, DONE)
  - byte-enable constants
- Sub-module load_formatter (combinational): inputs dmem_rdata, addr[1:0], Funct3; output the 32-bit extended value. It is reused by the single-cycle model.

Test Plan:
- LW addr 0x100, memory 0xDEADBEEF, ready after 2 wait cycles → StallM high 4 cycles, dmem_be=1111, ReadDataM=0xDEADBEEF in DONE.
- LB addr 0x103, word 0x80123456, then LBU same address → ReadDataM=0xFFFFFF80 then 0x00000080.
- SH addr 0x202, WriteDataM=0x0000ABCD, ready immediately → dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD, ReadDataM unchanged, StallM high 2 cycles.
- MemReadM=MemWriteM=1 with Funct3=000, addr 0x1 → store: be=0010, we=1.
- rst asserted while in REQ with ready low → dmem_req=0 and StallM=0 immediately; FSM IDLE; no completion after rst releases with no pending op.
- LSU_MISALIGN_TRAP_EN: LW addr 0x102 → MisalignM=1, dmem_req stays 0, StallM=0. Without the macro: be=1111, addr 0x100, normal completion.
